// File: rtl/checker_pkg.sv
// Shared types and helpers for checker_multi: FSM state codes, log interval,
// lowest-set-bit search used for first-failure channel capture.
package checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FAILED = 2'd2
    } state_t;

    localparam int unsigned LOG_EVERY = 1000;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 32; i > 0; i--) begin
            if (v[i-1]) begin
                idx = 5'(i - 1);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/checker_multi_pipe_delay.sv
// pipe_delay: DEPTH-stage register pipeline, cleared to zero by an
// asynchronous active-low reset; DEPTH=0 degenerates to a plain wire.
module pipe_delay #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 0
) (
    input  logic         clk,
    input  logic         reset_L,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset_L;
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] stage [DEPTH];

            // Shift register; reset flushes every stage to zero.
            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/checker_multi.sv
// checker_multi: multi-lane behavioural-vs-structural output comparator with
// alignment delay, arming, sticky failure, saturating error count and
// first-failure capture. Optional simulation logging: CHECKER_MULTI_LOG_EN.
module checker_multi
    import checker_pkg::*;
#(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DELAY    = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic [CHANNELS*WIDTH-1:0] data_c,
    input  logic [CHANNELS-1:0]       valid_c,
    input  logic [CHANNELS*WIDTH-1:0] data_e,
    input  logic [CHANNELS-1:0]       valid_e,
    output logic                      checks_out,
    output logic [CHANNELS-1:0]       mismatch_ch,
    output logic                      armed,
    output logic                      sticky_err,
    output logic [CNT_W-1:0]          err_count,
    output logic [4:0]                first_ch,
    output logic [CNT_W-1:0]          first_cycle
);

    localparam int unsigned DW = CHANNELS * WIDTH;

    logic [DW-1:0]       dc;
    logic [CHANNELS-1:0] vc;
    logic [CHANNELS-1:0] m;
    logic                active;
    logic [CNT_W-1:0]    stamp;
    state_t              state;
    state_t              state_nxt;
    logic                capture;
    logic                count_en;

    pipe_delay #(
        .W     (DW + CHANNELS),
        .DEPTH (DELAY)
    ) u_align (
        .clk     (clk),
        .reset_L (reset_L),
        .din     ({valid_c, data_c}),
        .dout    ({vc, dc})
    );

    // Per-lane mismatch on aligned data; both-invalid counts as a match.
    always_comb begin
        m = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            m[i] = (vc[i] != valid_e[i]) |
                   (vc[i] & valid_e[i] & (dc[i*WIDTH +: WIDTH] != data_e[i*WIDTH +: WIDTH]));
        end
        active = |(vc & valid_e);
    end

    // Free-running cycle stamp, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stamp <= '0;
        end else if (stamp != '1) begin
            stamp <= stamp + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus count/capture strobes.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        count_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active && !(|m)) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                count_en = |m;
                if (|m) begin
                    state_nxt = ST_FAILED;
                    capture   = 1'b1;
                end
            end
            ST_FAILED: begin
                count_en = |m;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered comparison results, error counter and first-failure capture.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            checks_out  <= 1'b1;
            mismatch_ch <= '0;
            err_count   <= '0;
            first_ch    <= '0;
            first_cycle <= '0;
        end else if (state == ST_IDLE) begin
            checks_out  <= 1'b1;
            mismatch_ch <= '0;
        end else begin
            checks_out  <= ~|m;
            mismatch_ch <= m;
            if (count_en && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (capture) begin
                first_ch    <= lowest_set(32'(m));
                first_cycle <= stamp;
            end
        end
    end

    assign armed      = (state != ST_IDLE);
    assign sticky_err = (state == ST_FAILED);

`ifdef CHECKER_MULTI_LOG_EN
    // Simulation-only reporting of the first failure and periodic totals.
    always_ff @(posedge clk) begin
        if (reset_L && capture) begin
            $display("%0t ch=%0d c=%h e=%h Error: Modules differ!!", $time,
                     lowest_set(32'(m)),
                     dc[int'(lowest_set(32'(m))) * WIDTH +: WIDTH],
                     data_e[int'(lowest_set(32'(m))) * WIDTH +: WIDTH]);
        end
        if (reset_L && count_en && (err_count != '1) &&
            (((64'(err_count) + 64'd1) % 64'(LOG_EVERY)) == 64'd0)) begin
            $display("%0t checker_multi: %0d mismatching cycles so far", $time,
                     64'(err_count) + 64'd1);
        end
    end
`endif

endmodule

// File: tb/tb_checker_multi.sv
// Self-checking bench for checker_multi: four instances (default, DELAY=2,
// DELAY=1, CNT_W=4) driven per scenario; expectations queued at drive time
// and popped one clock later.
module tb_checker_multi;

    localparam int W  = 5;
    localparam int CH = 4;
    localparam int DW = W * CH;

    typedef struct {
        logic          chk;
        logic [CH-1:0] mm;
        logic          arm;
        logic          sticky;
        logic [15:0]   cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t q0[$], q1[$], q2[$], q4[$];

    // default instance
    logic [DW-1:0] data_c, data_e;
    logic [CH-1:0] valid_c, valid_e;
    logic chk0, arm0, st0;
    logic [CH-1:0] mm0;
    logic [15:0] cnt0, fcy0;
    logic [4:0] fch0;

    // delay instances share one stream
    logic [DW-1:0] ddata_c, ddata_e;
    logic [CH-1:0] dvalid_c, dvalid_e;
    logic chk1, arm1, st1, chk2, arm2, st2;
    logic [CH-1:0] mm1, mm2;
    logic [15:0] cnt1, fcy1, cnt2, fcy2;
    logic [4:0] fch1, fch2;

    // narrow-counter instance
    logic [DW-1:0] sdata_c, sdata_e;
    logic [CH-1:0] svalid_c, svalid_e;
    logic chk4, arm4, st4;
    logic [CH-1:0] mm4;
    logic [3:0] cnt4, fcy4;
    logic [4:0] fch4;

    checker_multi #(.WIDTH(W), .CHANNELS(CH), .DELAY(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_L(reset_L), .data_c(data_c), .valid_c(valid_c),
        .data_e(data_e), .valid_e(valid_e), .checks_out(chk0), .mismatch_ch(mm0),
        .armed(arm0), .sticky_err(st0), .err_count(cnt0), .first_ch(fch0),
        .first_cycle(fcy0));

    checker_multi #(.WIDTH(W), .CHANNELS(CH), .DELAY(2), .CNT_W(16)) dut_d2 (
        .clk(clk), .reset_L(reset_L), .data_c(ddata_c), .valid_c(dvalid_c),
        .data_e(ddata_e), .valid_e(dvalid_e), .checks_out(chk2), .mismatch_ch(mm2),
        .armed(arm2), .sticky_err(st2), .err_count(cnt2), .first_ch(fch2),
        .first_cycle(fcy2));

    checker_multi #(.WIDTH(W), .CHANNELS(CH), .DELAY(1), .CNT_W(16)) dut_d1 (
        .clk(clk), .reset_L(reset_L), .data_c(ddata_c), .valid_c(dvalid_c),
        .data_e(ddata_e), .valid_e(dvalid_e), .checks_out(chk1), .mismatch_ch(mm1),
        .armed(arm1), .sticky_err(st1), .err_count(cnt1), .first_ch(fch1),
        .first_cycle(fcy1));

    checker_multi #(.WIDTH(W), .CHANNELS(CH), .DELAY(0), .CNT_W(4)) dut_c4 (
        .clk(clk), .reset_L(reset_L), .data_c(sdata_c), .valid_c(svalid_c),
        .data_e(sdata_e), .valid_e(svalid_e), .checks_out(chk4), .mismatch_ch(mm4),
        .armed(arm4), .sticky_err(st4), .err_count(cnt4), .first_ch(fch4),
        .first_cycle(fcy4));

    function automatic exp_t mk(input logic c, input logic [CH-1:0] mm,
                                input logic a, input logic s, input logic [15:0] n);
        exp_t e;
        e.chk = c; e.mm = mm; e.arm = a; e.sticky = s; e.cnt = n;
        return e;
    endfunction

    task automatic zero_inputs();
        data_c = '0; data_e = '0; valid_c = '0; valid_e = '0;
        ddata_c = '0; ddata_e = '0; dvalid_c = '0; dvalid_e = '0;
        sdata_c = '0; sdata_e = '0; svalid_c = '0; svalid_e = '0;
    endtask

    // Leaves the bench at posedge+1 with reset just released; next drive is stamp 0.
    task automatic do_reset();
        @(posedge clk); #1;
        reset_L = 1'b0;
        zero_inputs();
        @(posedge clk); #1;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        zero_inputs();
        reset_L = 1'b1;
        #1 reset_L = 1'b0;
        #2;
        if ({chk0, mm0, arm0, st0, cnt0, fch0, fcy0} !== {1'b1, 4'b0, 1'b0, 1'b0, 16'd0, 5'd0, 16'd0}) begin
            bad++;
            $display("FAIL reset got chk=%b mm=%b arm=%b st=%b cnt=%0d fch=%0d fcy=%0d want 1/0000/0/0/0/0/0",
                     chk0, mm0, arm0, st0, cnt0, fch0, fcy0);
        end
        total++;
        if ({chk2, arm2, st2, cnt2, chk1, arm1, st1, cnt1} !== {3'b100, 16'd0, 3'b100, 16'd0}) begin
            bad++;
            $display("FAIL reset_delay got chk2=%b arm2=%b chk1=%b arm1=%b want 1 0 1 0", chk2, arm2, chk1, arm1);
        end
        total++;
    endtask

    task automatic test_matched();
        exp_t e;
        logic [DW-1:0] r;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            r = DW'($urandom);
            data_c = r; data_e = r; valid_c = '1; valid_e = '1;
            q0.push_back(mk(1'b1, 4'b0000, 1'b1, 1'b0, 16'd0));
            @(posedge clk); #1;
            e = q0.pop_front();
            if ({chk0, mm0, arm0, st0, cnt0} !== {e.chk, e.mm, e.arm, e.sticky, e.cnt}) begin
                bad++;
                $display("FAIL matched k=%0d got chk=%b mm=%b arm=%b st=%b cnt=%0d want chk=%b mm=%b arm=%b st=%b cnt=%0d",
                         k, chk0, mm0, arm0, st0, cnt0, e.chk, e.mm, e.arm, e.sticky, e.cnt);
            end
            total++;
        end
    endtask

    // Startup garbage for stamps 0..2, arm at 3, faults at stamps 20 and 22.
    task automatic test_startup_and_fault();
        exp_t e;
        logic [DW-1:0] r;
        logic [DW-1:0] f23, f1;
        f23 = 20'h08400;
        f1  = 20'h00020;
        do_reset();
        for (int k = 0; k < 24; k++) begin
            r = DW'($urandom);
            valid_c = '1; valid_e = '1;
            if (k < 3) begin
                data_c = '0; data_e = '1;
            end else if (k == 20) begin
                data_c = r; data_e = r ^ f23;
            end else if (k == 22) begin
                data_c = r; data_e = r ^ f1;
            end else begin
                data_c = r; data_e = r;
            end
            q0.push_back(mk(!(k == 20 || k == 22),
                            (k == 20) ? 4'b1100 : ((k == 22) ? 4'b0010 : 4'b0000),
                            k >= 3, k >= 20,
                            (k >= 22) ? 16'd2 : ((k >= 20) ? 16'd1 : 16'd0)));
            @(posedge clk); #1;
            e = q0.pop_front();
            if ({chk0, mm0, arm0, st0, cnt0} !== {e.chk, e.mm, e.arm, e.sticky, e.cnt}) begin
                bad++;
                $display("FAIL fault k=%0d got chk=%b mm=%b arm=%b st=%b cnt=%0d want chk=%b mm=%b arm=%b st=%b cnt=%0d",
                         k, chk0, mm0, arm0, st0, cnt0, e.chk, e.mm, e.arm, e.sticky, e.cnt);
            end
            total++;
            if (k >= 20) begin
                if ({fch0, fcy0} !== {5'd2, 16'd20}) begin
                    bad++;
                    $display("FAIL first_capture k=%0d got ch=%0d cycle=%0d want ch=2 cycle=20", k, fch0, fcy0);
                end
                total++;
            end
        end
    endtask

    task automatic test_valid_disagree();
        exp_t e;
        logic [DW-1:0] r;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            r = DW'($urandom);
            data_c = r; data_e = r; valid_c = '1;
            valid_e = (k == 1) ? 4'b1110 : 4'b1111;
            q0.push_back(mk(k == 0, (k == 1) ? 4'b0001 : 4'b0000, 1'b1, k == 1, 16'(k)));
            @(posedge clk); #1;
            e = q0.pop_front();
            if ({chk0, mm0, arm0, st0, cnt0} !== {e.chk, e.mm, e.arm, e.sticky, e.cnt}) begin
                bad++;
                $display("FAIL valid_dis k=%0d got chk=%b mm=%b arm=%b st=%b cnt=%0d want chk=%b mm=%b arm=%b st=%b cnt=%0d",
                         k, chk0, mm0, arm0, st0, cnt0, e.chk, e.mm, e.arm, e.sticky, e.cnt);
            end
            total++;
        end
        if ({fch0, fcy0} !== {5'd0, 16'd1}) begin
            bad++;
            $display("FAIL valid_dis_first got ch=%0d cycle=%0d want ch=0 cycle=1", fch0, fcy0);
        end
        total++;
        // asynchronous clear mid-operation, no clock edge in between
        reset_L = 1'b0;
        #2;
        if ({chk0, mm0, arm0, st0, cnt0, fch0, fcy0} !== {1'b1, 4'b0, 1'b0, 1'b0, 16'd0, 5'd0, 16'd0}) begin
            bad++;
            $display("FAIL async_reset0 got chk=%b mm=%b arm=%b st=%b cnt=%0d fch=%0d fcy=%0d want 1/0000/0/0/0/0/0",
                     chk0, mm0, arm0, st0, cnt0, fch0, fcy0);
        end
        total++;
        #1 reset_L = 1'b1;
    endtask

    // Structural stream lags behavioural by two cycles; first two words equal.
    task automatic test_delay();
        exp_t e;
        logic [DW-1:0] w [12];
        logic [DW-1:0] mask;
        w[0] = DW'($urandom);
        w[1] = w[0];
        for (int k = 2; k < 12; k++) begin
            for (int i = 0; i < CH; i++) mask[i*W +: W] = W'($urandom_range(1, 31));
            w[k] = w[k-1] ^ mask;
        end
        do_reset();
        for (int k = 0; k < 12; k++) begin
            ddata_c = w[k]; dvalid_c = '1;
            if (k >= 2) begin
                ddata_e = w[k-2]; dvalid_e = '1;
            end else begin
                ddata_e = '0; dvalid_e = '0;
            end
            q2.push_back(mk(1'b1, 4'b0000, k >= 2, 1'b0, 16'd0));
            q1.push_back(mk(k < 3, (k >= 3) ? 4'b1111 : 4'b0000, k >= 2, k >= 3,
                            (k >= 3) ? 16'(k - 2) : 16'd0));
            @(posedge clk); #1;
            e = q2.pop_front();
            if ({chk2, mm2, arm2, st2, cnt2} !== {e.chk, e.mm, e.arm, e.sticky, e.cnt}) begin
                bad++;
                $display("FAIL delay2 k=%0d got chk=%b mm=%b arm=%b st=%b cnt=%0d want chk=%b mm=%b arm=%b st=%b cnt=%0d",
                         k, chk2, mm2, arm2, st2, cnt2, e.chk, e.mm, e.arm, e.sticky, e.cnt);
            end
            total++;
            e = q1.pop_front();
            if ({chk1, mm1, arm1, st1, cnt1} !== {e.chk, e.mm, e.arm, e.sticky, e.cnt}) begin
                bad++;
                $display("FAIL delay1 k=%0d got chk=%b mm=%b arm=%b st=%b cnt=%0d want chk=%b mm=%b arm=%b st=%b cnt=%0d",
                         k, chk1, mm1, arm1, st1, cnt1, e.chk, e.mm, e.arm, e.sticky, e.cnt);
            end
            total++;
        end
        if ({fch1, fcy1, fch2, fcy2} !== {5'd0, 16'd3, 5'd0, 16'd0}) begin
            bad++;
            $display("FAIL delay_first got d1 ch=%0d cyc=%0d d2 ch=%0d cyc=%0d want 0 3 0 0", fch1, fcy1, fch2, fcy2);
        end
        total++;
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [DW-1:0] r;
        logic bad_cyc;
        do_reset();
        for (int k = 0; k < 22; k++) begin
            r = DW'($urandom);
            bad_cyc = (k >= 1 && k <= 20);
            sdata_c = r; sdata_e = r; svalid_c = '1;
            svalid_e = bad_cyc ? 4'b1110 : 4'b1111;
            q4.push_back(mk(!bad_cyc, bad_cyc ? 4'b0001 : 4'b0000, 1'b1, k >= 1,
                            (k >= 15) ? 16'd15 : 16'(k)));
            @(posedge clk); #1;
            e = q4.pop_front();
            if ({chk4, mm4, arm4, st4, cnt4} !== {e.chk, e.mm, e.arm, e.sticky, e.cnt[3:0]}) begin
                bad++;
                $display("FAIL saturate k=%0d got chk=%b mm=%b arm=%b st=%b cnt=%0d want chk=%b mm=%b arm=%b st=%b cnt=%0d",
                         k, chk4, mm4, arm4, st4, cnt4, e.chk, e.mm, e.arm, e.sticky, e.cnt[3:0]);
            end
            total++;
        end
        if (fcy4 !== 4'd1) begin
            bad++;
            $display("FAIL saturate_first got cycle=%0d want 1", fcy4);
        end
        total++;
        reset_L = 1'b0;
        #2;
        if ({chk4, mm4, arm4, st4, cnt4, fch4, fcy4} !== {1'b1, 4'b0, 1'b0, 1'b0, 4'd0, 5'd0, 4'd0}) begin
            bad++;
            $display("FAIL async_reset4 got chk=%b mm=%b arm=%b st=%b cnt=%0d fch=%0d fcy=%0d want 1/0000/0/0/0/0/0",
                     chk4, mm4, arm4, st4, cnt4, fch4, fcy4);
        end
        total++;
        #1 reset_L = 1'b1;
    endtask

    initial begin
        test_reset();
        test_matched();
        test_startup_and_fault();
        test_valid_disagree();
        test_delay();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/checker_multi.md
Name: checker_multi

Overview:
- Parametrised, clocked successor to the single-channel demux checker.
- Compares behavioural (_c) and structural (_e) outputs of a DUT pair across CHANNELS lanes of WIDTH bits each, with valid qualification.
- A programmable alignment delay is applied to the behavioural side.
- Adds arming, a sticky failure state, a saturating mismatch counter and first-failure capture; sits in every muxes/ testbench beside the DUT pair.

Parameters:
- WIDTH, 5, data bits per channel
- CHANNELS, 4, number of compared lanes (1..32)
- DELAY, 0, pipeline stages inserted on behavioural data and valid (0 = none)
- CNT_W, 16, width of mismatch counter and cycle stamp

Ports:
- clk  in  1  clock, all state on rising edge
- reset_L  in  1  asynchronous, active-low reset
- data_c  in  CHANNELS*WIDTH  behavioural data; channel i at [i*WIDTH +: WIDTH]
- valid_c  in  CHANNELS  behavioural valid per channel
- data_e  in  CHANNELS*WIDTH  structural data
- valid_e  in  CHANNELS  structural valid per channel
- checks_out  out  1  1 = no mismatch in the last compared cycle (or not yet armed)
- mismatch_ch  out  CHANNELS  per-channel mismatch of the last compared cycle
- armed  out  1  checker armed
- sticky_err  out  1  set on the first counted mismatch; held until reset
- err_count  out  CNT_W  count of cycles with any counted mismatch, saturating
- first_ch  out  5  lowest-index channel that mismatched in the first failing cycle
- first_cycle  out  CNT_W  cycle stamp of the first failure

Behaviour:
- Alignment: data_c/valid_c pass through DELAY register stages; the aligned values are dc/vc. Structural inputs are used undelayed.
- Per-channel mismatch m[i] = (vc[i] != valid_e[i]) | (vc[i] & valid_e[i] & (dc[i] != data_e[i])). A channel invalid on both sides is a match.
- A cycle is "active" when any i has vc[i] & valid_e[i].
- Comparison result is registered: outputs reflect the inputs presented one clk earlier (total latency DELAY+1 from data_c).
- Reset (reset_L low, async):
  - checks_out=1; mismatch_ch=0; armed=0; sticky_err=0; err_count=0; first_ch=0; first_cycle=0.
  - Cycle stamp is 0. Delay line is cleared to valid=0.
- Cycle stamp: free-running, increments every clk after reset, saturates at all-ones.
- FSM, state codes in package:
  - IDLE: mismatches are ignored (checks_out stays 1, mismatch_ch 0, no count). This tolerates X/startup garbage.
  - IDLE -> ARMED on the first active cycle with m==0; armed=1 from the next edge.
  - ARMED: each cycle, mismatch_ch<=m and checks_out<=~|m. If |m, err_count increments and the FSM goes to FAILED.
  - FAILED: comparison and counting continue; sticky_err=1; no exit except reset.
  - The ARMED->FAILED edge captures first_ch = lowest i with m[i]=1, and first_cycle = current stamp. Both are frozen afterwards.
- err_count saturates at 2^CNT_W-1 and never wraps.
- Multiple channels mismatching in one cycle count as one increment; first_ch takes the lowest index.
- Reset asserted mid-operation returns to IDLE immediately. The delay line is flushed, so the first DELAY cycles after release compare vc=0 against valid_e.

Optional Feature:
- Macro: CHECKER_MULTI_LOG_EN.
- Defined: on each ARMED->FAILED transition the block prints a simulation $display with $time, channel, both data values and " Error: Modules differ!!".
  - Additionally, every 1000th counted mismatch prints a summary line.
- Undefined: no $display statements are compiled; all port behaviour is identical.

Decomposition:
- Package checker_pkg holds:
  - state localparams ST_IDLE=2'd0, ST_ARMED=2'd1, ST_FAILED=2'd2
  - the log interval constant LOG_EVERY=1000
  - a function for lowest-set-bit index
- Sub-module pipe_delay (params W, DEPTH):
  - async active-low reset clears it to 0
  - DEPTH=0 is a wire-through
  - instantiated once for {valid_c, data_c}.

Test Plan:
- Matched stream, WIDTH=5, CHANNELS=4, DELAY=0: identical random data, all valids 1 for 100 cycles -> armed=1 from cycle 2, checks_out=1, err_count=0, sticky_err=0.
- Startup garbage: data_e=5'h1F vs data_c=0 for 3 cycles, then matching -> no count, sticky_err=0, armed asserts after the first matching cycle.
- Single fault: after arming, corrupt channel 2 and channel 3 in the same cycle at stamp 20 -> mismatch_ch=4'b1100, checks_out=0 one cycle later, first_ch=2, first_cycle=20, err_count=1, sticky_err=1. Next matching cycle gives checks_out=1 while sticky_err stays 1.
- Valid disagreement: valid_c[0]=1, valid_e[0]=0 with equal data -> counted mismatch on channel 0.
- DELAY=2: structural stream lags behavioural by 2 cycles -> no mismatch. With DELAY=1 on the same stream -> failure within the first armed cycle.
- Saturation and reset: CNT_W=4, 20 mismatch cycles -> err_count holds 15. Pulsing reset_L low mid-stream clears all outputs asynchronously, without a clk edge.
